// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared constants and helpers for the multi-channel counter.
//   MODE_WRAP / MODE_SAT : boundary behaviour selectors for the Mode parameter
//   clamp(value, limit)  : returns value limited to at most limit
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Loaded values beyond the modulus are pinned to the top of the range
  function automatic int unsigned clamp(input int unsigned value,
                                        input int unsigned limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/counter_channel.sv
// -----------------------------------------------------------------------------
// counter_channel
// One Size-bit up/down counter with synchronous load, modulo Limit+1 counting,
// wrap or saturate at the boundaries, a registered terminal-count pulse and a
// sticky overflow flag.
// Ports:
//   clock          : rising-edge clock
//   reset          : synchronous active-low reset
//   enable         : count enable
//   up             : 1 = increment, 0 = decrement
//   load           : synchronous load strobe (beats enable)
//   load_value     : load data, clamped to Limit
//   clear_overflow : clears the sticky flag unless a boundary event coincides
//   count          : current count
//   tc             : one-cycle pulse following a boundary event
//   overflow       : sticky boundary-event flag
// -----------------------------------------------------------------------------
module counter_channel
  import counter_pkg::*;
#(
  parameter int          Size  = 5,
  parameter int unsigned Limit = (1 << Size) - 1,
  parameter int          Mode  = MODE_WRAP
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            up,
  input  logic            load,
  input  logic [Size-1:0] load_value,
  input  logic            clear_overflow,
  output logic [Size-1:0] count,
  output logic            tc,
  output logic            overflow
);

  localparam logic [Size-1:0] LIMIT_V = Size'(Limit);
  localparam logic [Size-1:0] ZERO_V  = '0;
  localparam logic [Size-1:0] ONE_V   = Size'(1);

  logic [Size-1:0] r_count;
  logic            r_tc;
  logic            r_overflow;

  logic            w_atTop;
  logic            w_atBottom;
  logic            w_boundary;
  logic [Size-1:0] w_loadClamped;
  logic [Size-1:0] w_nextCount;

  assign w_atTop       = (r_count >= LIMIT_V);
  assign w_atBottom    = (r_count == ZERO_V);
  assign w_loadClamped = Size'(clamp(32'(load_value), Limit));

  // A boundary event is a counting step that would leave the 0..Limit range
  assign w_boundary = enable && !load && (up ? w_atTop : w_atBottom);

  // Next count: load first, then counting, otherwise hold
  always_comb begin
    w_nextCount = r_count;
    if (load) begin
      w_nextCount = w_loadClamped;
    end else if (enable) begin
      if (up) begin
        if (w_atTop)
          w_nextCount = (Mode == MODE_SAT) ? LIMIT_V : ZERO_V;
        else
          w_nextCount = r_count + ONE_V;
      end else begin
        if (w_atBottom)
          w_nextCount = (Mode == MODE_SAT) ? ZERO_V : LIMIT_V;
        else
          w_nextCount = r_count - ONE_V;
      end
    end
  end

  // State registers; a boundary event in the same cycle as a clear keeps the flag set
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count    <= '0;
      r_tc       <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_nextCount;
      r_tc    <= w_boundary;
      if (w_boundary)
        r_overflow <= 1'b1;
      else if (clear_overflow)
        r_overflow <= 1'b0;
    end
  end

  assign count    = r_count;
  assign tc       = r_tc;
  assign overflow = r_overflow;

endmodule

// File: rtl/counter_multi.sv
// -----------------------------------------------------------------------------
// counter_multi
// Channels independent Size-bit counters sharing a modulus (Limit+1) and a
// wrap/saturate Mode. Per-channel vectors are packed with channel i in
// bits [i*Size +: Size] (or bit i for single-bit signals).
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-low reset
//   enable, up     : per-channel count enable and direction
//   load           : per-channel synchronous load strobe
//   load_value     : per-channel load data
//   clear_overflow : per-channel sticky-flag clear
//   count          : per-channel count
//   tc             : per-channel registered terminal-count pulse
//   overflow       : per-channel sticky boundary-event flag
// -----------------------------------------------------------------------------
module counter_multi
  import counter_pkg::*;
#(
  parameter int          Size     = 5,
  parameter int          Channels = 2,
  parameter int unsigned Limit    = (1 << Size) - 1,
  parameter int          Mode     = MODE_WRAP
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [Channels-1:0]      enable,
  input  logic [Channels-1:0]      up,
  input  logic [Channels-1:0]      load,
  input  logic [Channels*Size-1:0] load_value,
  input  logic [Channels-1:0]      clear_overflow,
  output logic [Channels*Size-1:0] count,
  output logic [Channels-1:0]      tc,
  output logic [Channels-1:0]      overflow
);

  for (genvar i = 0; i < Channels; i++) begin : g_channel
    counter_channel #(
      .Size  (Size),
      .Limit (Limit),
      .Mode  (Mode)
    ) u_channel (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable[i]),
      .up             (up[i]),
      .load           (load[i]),
      .load_value     (load_value[i*Size +: Size]),
      .clear_overflow (clear_overflow[i]),
      .count          (count[i*Size +: Size]),
      .tc             (tc[i]),
      .overflow       (overflow[i])
    );
  end

endmodule

// File: tb/tb_counter_multi.sv
// -----------------------------------------------------------------------------
// tb_counter_multi
// Drives a wrapping and a saturating counter_multi (Size=4, Channels=2,
// Limit=9) from the same inputs and compares both against a behavioural model
// after every edge, with directed scenarios followed by random traffic.
// -----------------------------------------------------------------------------
module tb_counter_multi;
  import counter_pkg::*;

  localparam int SIZE  = 4;
  localparam int CHANS = 2;
  localparam int LIMIT = 9;

  logic                  clock;
  logic                  reset;
  logic [CHANS-1:0]      enable;
  logic [CHANS-1:0]      up;
  logic [CHANS-1:0]      load;
  logic [CHANS*SIZE-1:0] loadValue;
  logic [CHANS-1:0]      clearOverflow;

  logic [CHANS*SIZE-1:0] countWrap, countSat;
  logic [CHANS-1:0]      tcWrap, tcSat, ovWrap, ovSat;

  int vectorCount = 0;
  int missCount   = 0;

  // Model state indexed [mode][channel]; mode 0 = wrap, mode 1 = saturate
  int mCount [2][CHANS];
  int mTc    [2][CHANS];
  int mOv    [2][CHANS];

  counter_multi #(.Size(SIZE), .Channels(CHANS), .Limit(LIMIT), .Mode(MODE_WRAP)) dutWrap (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_value(loadValue), .clear_overflow(clearOverflow),
    .count(countWrap), .tc(tcWrap), .overflow(ovWrap)
  );

  counter_multi #(.Size(SIZE), .Channels(CHANS), .Limit(LIMIT), .Mode(MODE_SAT)) dutSat (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_value(loadValue), .clear_overflow(clearOverflow),
    .count(countSat), .tc(tcSat), .overflow(ovSat)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int getCount(int m, int ch);
    return (m == 0) ? int'(countWrap[ch*SIZE +: SIZE]) : int'(countSat[ch*SIZE +: SIZE]);
  endfunction

  function automatic int getTc(int m, int ch);
    return (m == 0) ? int'(tcWrap[ch]) : int'(tcSat[ch]);
  endfunction

  function automatic int getOv(int m, int ch);
    return (m == 0) ? int'(ovWrap[ch]) : int'(ovSat[ch]);
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectorCount++;
    if (observed != expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Model of one clock edge, written from the counting rules in plain integers
  task automatic stepModel();
    for (int m = 0; m < 2; m++) begin
      for (int ch = 0; ch < CHANS; ch++) begin
        int lv;
        int nxt;
        bit event_;
        lv     = int'(loadValue[ch*SIZE +: SIZE]);
        event_ = 1'b0;
        nxt    = mCount[m][ch];
        if (!reset) begin
          mCount[m][ch] = 0;
          mTc[m][ch]    = 0;
          mOv[m][ch]    = 0;
        end else begin
          if (load[ch]) begin
            nxt = (lv > LIMIT) ? LIMIT : lv;
          end else if (enable[ch]) begin
            nxt = up[ch] ? mCount[m][ch] + 1 : mCount[m][ch] - 1;
            if (nxt > LIMIT || nxt < 0) begin
              event_ = 1'b1;
              if (m == 0) nxt = (nxt > LIMIT) ? 0 : LIMIT;
              else        nxt = mCount[m][ch];
            end
          end
          mCount[m][ch] = nxt;
          mTc[m][ch]    = event_ ? 1 : 0;
          if (event_) mOv[m][ch] = 1;
          else if (clearOverflow[ch]) mOv[m][ch] = 0;
        end
      end
    end
  endtask

  // One clock: advance the model, let the edge happen, then compare everything
  task automatic applyStimulus();
    stepModel();
    @(posedge clock);
    #1;
    for (int m = 0; m < 2; m++) begin
      for (int ch = 0; ch < CHANS; ch++) begin
        checkOutput($sformatf("m%0d ch%0d count", m, ch), getCount(m, ch), mCount[m][ch]);
        checkOutput($sformatf("m%0d ch%0d tc", m, ch), getTc(m, ch), mTc[m][ch]);
        checkOutput($sformatf("m%0d ch%0d overflow", m, ch), getOv(m, ch), mOv[m][ch]);
      end
    end
  endtask

  initial begin
    reset = 1'b0; enable = '0; up = '0; load = '0; loadValue = '0; clearOverflow = '0;
    for (int m = 0; m < 2; m++)
      for (int ch = 0; ch < CHANS; ch++) begin
        mCount[m][ch] = 0; mTc[m][ch] = 0; mOv[m][ch] = 0;
      end

    // Reset held for two edges
    applyStimulus();
    applyStimulus();
    checkOutput("rst count", int'(countWrap), 0);
    checkOutput("rst tc", int'(tcWrap), 0);
    checkOutput("rst overflow", int'(ovWrap), 0);

    // Channel 0 counts up through the wrap
    reset = 1'b1; enable = 2'b01; up = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus();
      checkOutput("t1 ch0 count", getCount(0, 0), k % 10);
      checkOutput("t1 ch0 tc", int'(tcWrap[0]), (k == 10) ? 1 : 0);
    end
    checkOutput("t1 ch0 overflow", int'(ovWrap[0]), 1);
    checkOutput("t1 ch1 count", getCount(0, 1), 0);

    // Channel 1 loads 0 and wraps down; then an out-of-range load clamps
    enable = 2'b00; load = 2'b10; loadValue = 8'h00;
    applyStimulus();
    load = 2'b00; enable = 2'b10; up = 2'b00;
    applyStimulus();
    checkOutput("t2 ch1 wrap", getCount(0, 1), 9);
    checkOutput("t2 ch1 tc", int'(tcWrap[1]), 1);
    applyStimulus();
    checkOutput("t2 ch1 dec", getCount(0, 1), 8);
    checkOutput("t2 ch1 tc low", int'(tcWrap[1]), 0);
    enable = 2'b00; load = 2'b10; loadValue = 8'hF0;
    applyStimulus();
    checkOutput("t2 ch1 clamp", getCount(0, 1), 9);
    checkOutput("t2 ch1 clamp tc", int'(tcWrap[1]), 0);

    // Saturating instance, channel 0
    load = 2'b01; loadValue = 8'h08;
    applyStimulus();
    load = 2'b00; enable = 2'b01; up = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      applyStimulus();
      checkOutput("t3 sat count", getCount(1, 0), 9);
      checkOutput("t3 sat tc", int'(tcSat[0]), (k > 1) ? 1 : 0);
    end
    enable = 2'b00; load = 2'b01; loadValue = 8'h00;
    applyStimulus();
    load = 2'b00; enable = 2'b01; up = 2'b00;
    applyStimulus();
    checkOutput("t3 sat low count", getCount(1, 0), 0);
    checkOutput("t3 sat low tc", int'(tcSat[0]), 1);

    // Load beats enable; reset beats load
    enable = 2'b00; load = 2'b01; loadValue = 8'h05;
    applyStimulus();
    checkOutput("t4 load5", getCount(0, 0), 5);
    enable = 2'b01; up = 2'b01; loadValue = 8'h02;
    applyStimulus();
    checkOutput("t4 load beats enable", getCount(0, 0), 2);
    reset = 1'b0; loadValue = 8'h07;
    applyStimulus();
    checkOutput("t4 reset beats load", getCount(0, 0), 0);
    checkOutput("t4 reset beats load sat", getCount(1, 0), 0);
    reset = 1'b1; load = 2'b00; enable = 2'b00;

    // Sticky flag: set wins over a simultaneous clear
    clearOverflow = 2'b11;
    applyStimulus();
    checkOutput("t5 cleared", int'(ovWrap[0]), 0);
    clearOverflow = 2'b00; load = 2'b01; loadValue = 8'h09;
    applyStimulus();
    load = 2'b00; enable = 2'b01; up = 2'b01; clearOverflow = 2'b01;
    applyStimulus();
    checkOutput("t5 set wins", int'(ovWrap[0]), 1);
    checkOutput("t5 wrap count", getCount(0, 0), 0);
    enable = 2'b00;
    applyStimulus();
    checkOutput("t5 clear", int'(ovWrap[0]), 0);
    clearOverflow = 2'b00;

    // Reset in the middle of counting
    enable = 2'b11; up = 2'b11;
    repeat (3) applyStimulus();
    reset = 1'b0;
    applyStimulus();
    checkOutput("t6 reset count", int'(countWrap), 0);
    checkOutput("t6 reset tc", int'(tcWrap), 0);
    checkOutput("t6 reset overflow", int'(ovWrap), 0);
    reset = 1'b1;
    applyStimulus();
    checkOutput("t6 resume ch0", getCount(0, 0), 1);
    checkOutput("t6 resume ch1", getCount(0, 1), 1);

    // Random traffic on both channels and both modes
    for (int n = 0; n < 400; n++) begin
      reset         = ($urandom_range(0, 39) != 0);
      enable        = 2'($urandom);
      up            = 2'($urandom);
      load          = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      loadValue     = 8'($urandom);
      clearOverflow = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/counter_multi.md
Name: counter_multi

Overview:
Parametrised successor to the single-channel up-counter. It holds Channels independent Size-bit counters. Each channel has its own enable, direction and synchronous load. All channels share a programmable modulus and a wrap-or-saturate mode. Each channel reports a terminal-count pulse and a sticky overflow flag. The block is driven from Verilog/Ruby benches in the same way as the existing counter.

Parameters:
Size, 5, width of each channel counter in bits.
Channels, 2, number of independent counter channels (>=1).
Limit, (1<<Size)-1, maximum count value; counting is modulo Limit+1; must be <= 2^Size-1.
Mode, 0, 0 = wrap at boundaries, 1 = saturate at boundaries (constants from counter_pkg).

Ports:
clock  input  1  rising-edge clock.
reset  input  1  synchronous, active-low reset: 0 on a rising clock edge resets all state.
enable  input  Channels  per-channel count enable.
up  input  Channels  per-channel direction: 1 = increment, 0 = decrement.
load  input  Channels  per-channel synchronous load strobe.
load_value  input  Channels*Size  per-channel load data; channel i occupies bits [i*Size +: Size].
clear_overflow  input  Channels  per-channel clear for the sticky overflow flag.
count  output  Channels*Size  per-channel current count, same packing as load_value.
tc  output  Channels  per-channel terminal-count pulse, registered.
overflow  output  Channels  per-channel sticky boundary-event flag.

Behaviour:
- All state updates on the rising edge of clock; no combinational paths from inputs to outputs.
- Reset (reset==0 at an edge): count=0, tc=0, overflow=0 for every channel. Reset overrides all other inputs, including mid-load and mid-count.
- Per-channel priority after reset: load > enable > hold.
- load=1: count <= min(load_value, Limit). Out-of-range values clamp to Limit. Load produces no tc and does not set overflow. enable is ignored that cycle.
- enable=1, load=0, up=1:
  - count<Limit: count+1.
  - count==Limit: boundary event; Mode 0 -> 0, Mode 1 -> hold at Limit.
- enable=1, load=0, up=0:
  - count>0: count-1.
  - count==0: boundary event; Mode 0 -> Limit, Mode 1 -> hold at 0.
- enable=0, load=0: count holds. tc=0.
- tc: high for exactly the one cycle following a boundary event, i.e. visible together with the wrapped or held value. In Mode 1, sustained enable at a boundary produces tc every cycle.
- overflow: set on a boundary event; cleared when clear_overflow=1. If set and clear occur in the same cycle, set wins (flag = 1).
- Arithmetic is exactly Size bits wide. When Limit == 2^Size-1, wrap is the natural modular result.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Latency: count reflects enable/load one cycle after the sampling edge.

Decomposition:
- Package counter_pkg: MODE_WRAP=0 and MODE_SAT=1 constants; a helper function clamp(value, limit).
- Sub-module counter_channel (ports clock, reset, enable, up, load, load_value, clear_overflow, count, tc, overflow; parameters Size, Limit, Mode). counter_multi instantiates it Channels times in a generate loop and packs/unpacks the vectors.

Test Plan:
All scenarios use Size=4, Channels=2, Limit=9, Mode=0 unless stated.
1. Reset and up-count: hold reset=0 for 2 cycles -> count=0, tc=0, overflow=0. Release; ch0 enable=1, up=1 for 10 cycles -> ch0 reads 1..9 then 0. tc[0]=1 only in the cycle count shows 0. overflow[0]=1. ch1 stays 0.
2. Down wrap with mixed loads: ch1 load_value=0, load; then enable=1, up=0 -> ch1 count=9, tc[1]=1. Next cycle 8, tc[1]=0. Separately, load 15 -> count=9 (clamp), no tc.
3. Saturate (Mode=1): load 8, enable up for 3 cycles -> 9, 9, 9. tc=1 on cycles 2 and 3. Load 0, enable down -> count stays 0, tc=1.
4. Priority: at count=5, assert load=1 (value 2) with enable=1, up=1 -> count=2 next cycle. Assert reset=0 with load=1 -> count=0.
5. Sticky flag: drive a boundary event with clear_overflow=1 in the same cycle -> overflow=1. Next cycle clear_overflow=1 with no event -> overflow=0.
6. Mid-operation reset: both channels counting; reset=0 for one edge -> all outputs 0 on that edge, counting resumes from 0 after release.
